// File: rtl/conversor_ps.sv
// Parallel-to-serial converter: valid/ready load, one bit per clk on Q framed by Q_valid.
// Define CONVERSOR_PS_PARITY_EN to append an even-parity bit to every frame.
module conversor_ps #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    output logic             ready,
    output logic             Q,
    output logic             Q_valid,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

`ifdef CONVERSOR_PS_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic r_par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;

    assign ready = (r_state == IDLE) & ~CLR;

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            Q       <= 1'b0;
            Q_valid <= 1'b0;
            done    <= 1'b0;
`ifdef CONVERSOR_PS_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    Q       <= 1'b0;
                    Q_valid <= 1'b0;
                    if (load) begin
                        r_shift <= D;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
`ifdef CONVERSOR_PS_PARITY_EN
                        r_par   <= ^D;
`endif
                    end
                end
                SHIFT: begin
                    // r_cnt counts bits already launched; at WIDTH the data part is finished
                    if (r_cnt == CNT_W'(WIDTH)) begin
`ifdef CONVERSOR_PS_PARITY_EN
                        Q       <= r_par;
                        Q_valid <= 1'b1;
                        r_state <= PARITY;
`else
                        Q       <= 1'b0;
                        Q_valid <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
`endif
                    end else begin
                        Q_valid <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (MSB_FIRST) begin
                            Q       <= r_shift[WIDTH-1];
                            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        end else begin
                            Q       <= r_shift[0];
                            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                        end
                    end
                end
`ifdef CONVERSOR_PS_PARITY_EN
                PARITY: begin
                    Q       <= 1'b0;
                    Q_valid <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
`endif
                default: begin
                    Q       <= 1'b0;
                    Q_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_ps.sv
// Directed bench for conversor_ps: MSB-first and LSB-first instances plus a serial-to-parallel model.
// Honours CONVERSOR_PS_PARITY_EN to expect the trailing parity bit.
module tb_conversor_ps;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] d_a = '0, d_b = '0;
    logic       load_a = 1'b0, load_b = 1'b0;
    logic       ready_a, q_a, qv_a, done_a;
    logic       ready_b, q_b, qv_b, done_b;
    logic [3:0] r_sp;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    conversor_ps #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .CLR(clr), .D(d_a), .load(load_a),
        .ready(ready_a), .Q(q_a), .Q_valid(qv_a), .done(done_a)
    );

    conversor_ps #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .CLR(clr), .D(d_b), .load(load_b),
        .ready(ready_b), .Q(q_b), .Q_valid(qv_b), .done(done_b)
    );

    // Receiving serial-to-parallel converter, clocked only on framed bits
    always @(posedge clk) begin
        if (clr) r_sp <= '0;
        else if (qv_a) r_sp <= {r_sp[2:0], q_a};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge of the done cycle.
    // seq[3] is the first bit expected on Q.
    task automatic frame_a(input logic [3:0] d, input logic [3:0] seq, input logic par,
                           input bit hold_load);
        d_a    = d;
        load_a = 1'b1;
        #1 check("ready_before_accept", ready_a, 1);
        @(negedge clk);
        load_a = hold_load;
        d_a    = ~d;
        check("qv_accept_cycle", qv_a, 0);
        check("ready_accept_cycle", ready_a, 0);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            check("q_bit", q_a, seq[i]);
            check("qv_bit", qv_a, 1);
            check("ready_busy", ready_a, 0);
            check("done_busy", done_a, 0);
        end
`ifdef CONVERSOR_PS_PARITY_EN
        @(negedge clk);
        check("q_parity", q_a, par);
        check("qv_parity", qv_a, 1);
        check("done_parity", done_a, 0);
`else
        check("par_unused", par, par ^ 1'b0);
        n_vec--;
`endif
        @(negedge clk);
        load_a = 1'b0;
        check("done_pulse", done_a, 1);
        check("qv_done_cycle", qv_a, 0);
        check("q_done_cycle", q_a, 0);
        check("ready_done_cycle", ready_a, 1);
    endtask

    initial begin
        // Reset held for two cycles, with a simultaneous load that must be dropped
        @(negedge clk);
        d_a = 4'b1111;
        load_a = 1'b1;
        @(negedge clk);
        check("rst_q", q_a, 0);
        check("rst_qv", qv_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ready", ready_a, 0);
        clr = 1'b0;
        load_a = 1'b0;
        #1 check("ready_after_rst", ready_a, 1);
        @(negedge clk);
        check("clr_load_not_captured", qv_a, 0);
        check("clr_load_ready", ready_a, 1);

        // Basic MSB-first frame with loopback into the receiver model
        frame_a(4'b1010, 4'b1010, 1'b0, 1'b0);
`ifdef CONVERSOR_PS_PARITY_EN
        check("loopback", r_sp, 4'b0100);
`else
        check("loopback", r_sp, 4'b1010);
`endif
        @(negedge clk);
        check("done_one_cycle", done_a, 0);
        check("idle_qv", qv_a, 0);

        // Back-to-back: load held high while busy, second word accepted in the done cycle
        frame_a(4'b0011, 4'b0011, 1'b0, 1'b1);
        frame_a(4'b1100, 4'b1100, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during the second bit of a frame
        d_a = 4'b1111;
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        @(negedge clk);
        check("abort_bit1", q_a, 1);
        @(negedge clk);
        check("abort_bit2_qv", qv_a, 1);
        clr = 1'b1;
        @(negedge clk);
        check("abort_qv", qv_a, 0);
        check("abort_done", done_a, 0);
        check("abort_ready_in_clr", ready_a, 0);
        clr = 1'b0;
        #1 check("abort_ready_after", ready_a, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", done_a, 0);
            check("abort_idle_qv", qv_a, 0);
        end
        frame_a(4'b0101, 4'b0101, 1'b0, 1'b0);
        @(negedge clk);

        // Parity-oriented words (data bits checked in both builds)
        frame_a(4'b1011, 4'b1011, 1'b1, 1'b0);
        @(negedge clk);
        frame_a(4'b1001, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);

        // LSB-first instance: D=1101 goes out as 1,0,1,1
        d_b = 4'b1101;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        d_b = 4'b0000;
        check("b_qv_accept", qv_b, 0);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] seq_b;
            seq_b = 4'b1011;
            @(negedge clk);
            check("b_q_bit", q_b, seq_b[i]);
            check("b_qv_bit", qv_b, 1);
        end
`ifdef CONVERSOR_PS_PARITY_EN
        @(negedge clk);
        check("b_q_parity", q_b, 1);
`endif
        @(negedge clk);
        check("b_done", done_b, 1);
        check("b_ready", ready_b, 1);
        @(negedge clk);
        check("b_done_cleared", done_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
